serial_subtractor: RTL and testbench



---
 rtl/serial_sub_pkg.sv | 15 +
 rtl/serial_subtractor_full_sub_cell.sv | 13 +
 rtl/serial_subtractor.sv | 109 ++++++++++
 tb/tb_serial_subtractor.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_sub_pkg.sv
// Shared types and sizing helpers for the bit-serial subtractor.
package serial_sub_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  // Counter reaches WIDTH after the last shift, so it needs room for WIDTH itself.
  function automatic int cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/serial_subtractor_full_sub_cell.sv
// One-bit full subtractor: d = x - y - bin, bo = borrow out.
module full_sub_cell (
  input  logic x,
  input  logic y,
  input  logic bin,
  output logic d,
  output logic bo
);

  assign d  = x ^ y ^ bin;
  assign bo = (~x & y) | (~(x ^ y) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor, LSB-first, one full_sub_cell reused WIDTH times.
// Optional signed-overflow output enabled by defining SERIAL_SUB_OVF_EN.
module serial_subtractor
  import serial_sub_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             bout
`ifdef SERIAL_SUB_OVF_EN
  ,
  output logic             ovf
`endif
);

  // state | meaning
  // IDLE  | in_ready=1, waiting for an operand pair
  // SHIFT | one difference bit per clock, LSB first
  // DONE  | result presented, held until out_ready

  localparam int CW = cnt_width(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  state_t           state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic             br;
  logic [CW-1:0]    cnt;
  logic             d;
  logic             bo;
  logic [WIDTH-1:0] diff_sh;

  full_sub_cell u_cell (
    .x   (a_sh[0]),
    .y   (b_sh[0]),
    .bin (br),
    .d   (d),
    .bo  (bo)
  );

  // New bit enters at the MSB so the word is aligned after WIDTH shifts.
  assign diff_sh = (diff >> 1) | (WIDTH'(d) << (WIDTH - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      a_sh      <= '0;
      b_sh      <= '0;
      br        <= 1'b0;
      cnt       <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      diff      <= '0;
      bout      <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
      ovf       <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_sh     <= a;
            b_sh     <= b;
            br       <= 1'b0;
            cnt      <= '0;
            in_ready <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
            ovf      <= 1'b0;
`endif
            state    <= SHIFT;
          end
        end
        SHIFT: begin
          a_sh <= a_sh >> 1;
          b_sh <= b_sh >> 1;
          br   <= bo;
          diff <= diff_sh;
          cnt  <= cnt + CW'(1);
          if (cnt == CNT_LAST) begin
            out_valid <= 1'b1;
            bout      <= bo;
`ifdef SERIAL_SUB_OVF_EN
            // On the last edge a_sh[0]/b_sh[0] hold the operand MSBs.
            ovf       <= (a_sh[0] ^ b_sh[0]) & (a_sh[0] ^ d);
`endif
            state     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench for serial_subtractor (WIDTH=8 main instance, WIDTH=1 corner instance).
module tb_serial_subtractor;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] a = '0;
  logic [7:0] b = '0;
  logic       out_valid;
  logic       out_ready = 1'b1;
  logic [7:0] diff;
  logic       bout;
  logic       ovf_v;

  logic       in_valid1 = 1'b0;
  logic       in_ready1;
  logic [0:0] a1 = '0;
  logic [0:0] b1 = '0;
  logic       out_valid1;
  logic       out_ready1 = 1'b1;
  logic [0:0] diff1;
  logic       bout1;

`ifdef SERIAL_SUB_OVF_EN
  logic ovf;
  logic ovf1;
  assign ovf_v = ovf;
`else
  assign ovf_v = 1'b0;
`endif

  serial_subtractor #(.WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
    .diff(diff), .bout(bout)
`ifdef SERIAL_SUB_OVF_EN
    , .ovf(ovf)
`endif
  );

  serial_subtractor #(.WIDTH(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid1), .in_ready(in_ready1),
    .a(a1), .b(b1), .out_valid(out_valid1), .out_ready(out_ready1),
    .diff(diff1), .bout(bout1)
`ifdef SERIAL_SUB_OVF_EN
    , .ovf(ovf1)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] d;
    logic       b;
    logic       o;
    int         acc;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  logic prev_valid = 1'b0;
  logic rnd_done = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %0h required %0h (t=%0t)", nm, act, req, $time);
    end
  endtask

  task automatic fail_now(input string nm);
    checks++;
    failures++;
    $display("FAIL %s (t=%0t)", nm, $time);
  endtask

  // Monitor: handshakes are sampled at negedge, before the edge that completes them.
  always @(negedge clk) begin
    if (rst_n) begin
      if (out_valid && !prev_valid) begin
        if (sb.size() == 0) fail_now("unexpected_out_valid");
        else chk("latency", 64'(cyc - sb[0].acc), 64'd8);
      end
      if (out_valid && out_ready) begin
        if (sb.size() == 0) fail_now("unexpected_result");
        else begin
          e = sb.pop_front();
          chk("diff", {56'd0, diff}, {56'd0, e.d});
          chk("bout", {63'd0, bout}, {63'd0, e.b});
`ifdef SERIAL_SUB_OVF_EN
          chk("ovf", {63'd0, ovf}, {63'd0, e.o});
`endif
        end
      end
    end
    prev_valid = out_valid;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] av, input logic [7:0] bv,
                      input logic [7:0] ed, input logic eb, input logic eo);
    int n = 0;
    tick();
    a = av;
    b = bv;
    in_valid = 1'b1;
    while (!in_ready && n < 200) begin
      tick();
      n++;
    end
    if (!in_ready) begin
      fail_now("accept_timeout");
      in_valid = 1'b0;
      return;
    end
    sb.push_back('{ed, eb, eo, cyc + 1});
    tick();
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 200) begin
      tick();
      n++;
    end
    if (sb.size() != 0) fail_now("drain_timeout");
  endtask

  logic [0:0] w1_a [3] = '{1'b0, 1'b1, 1'b1};
  logic [0:0] w1_b [3] = '{1'b1, 1'b0, 1'b1};
  logic [0:0] w1_d [3] = '{1'b1, 1'b1, 1'b0};
  logic       w1_bo[3] = '{1'b1, 1'b0, 1'b0};

  initial begin
    logic [7:0] ra, rb;
    logic [8:0] full;
    #12;
    chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
    chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_diff", {56'd0, diff}, 64'd0);
    chk("rst_bout", {63'd0, bout}, 64'd0);
    chk("rst_ovf", {63'd0, ovf_v}, 64'd0);
    tick();
    rst_n = 1'b1;

    // Directed vectors, out_ready held high.
    send(8'h05, 8'h03, 8'h02, 1'b0, 1'b0);
    send(8'h03, 8'h05, 8'hFE, 1'b1, 1'b0);
    send(8'h00, 8'hFF, 8'h01, 1'b1, 1'b0);
    send(8'h00, 8'h00, 8'h00, 1'b0, 1'b0);
    send(8'h80, 8'h01, 8'h7F, 1'b0, 1'b1);
    send(8'h10, 8'h01, 8'h0F, 1'b0, 1'b0);
    drain();

    // Backpressure: result held 5 cycles, second operand must wait.
    out_ready = 1'b0;
    send(8'h03, 8'h05, 8'hFE, 1'b1, 1'b0);
    fork
      send(8'h00, 8'hFF, 8'h01, 1'b1, 1'b0);
      begin
        int n = 0;
        while (!out_valid && n < 50) begin
          tick();
          n++;
        end
        if (!out_valid) fail_now("bp_valid_timeout");
        repeat (5) begin
          tick();
          chk("bp_out_valid", {63'd0, out_valid}, 64'd1);
          chk("bp_diff", {56'd0, diff}, 64'hFE);
          chk("bp_bout", {63'd0, bout}, 64'd1);
          chk("bp_in_ready", {63'd0, in_ready}, 64'd0);
          chk("bp_not_accepted", 64'(sb.size()), 64'd1);
        end
        out_ready = 1'b1;
      end
    join
    drain();

    // Reset in the middle of SHIFT.
    send(8'h55, 8'h11, 8'h44, 1'b0, 1'b0);
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    chk("mid_rst_in_ready", {63'd0, in_ready}, 64'd1);
    chk("mid_rst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("mid_rst_diff", {56'd0, diff}, 64'd0);
    chk("mid_rst_bout", {63'd0, bout}, 64'd0);
    sb.delete();
    tick();
    rst_n = 1'b1;
    #1;
    chk("post_rst_in_ready", {63'd0, in_ready}, 64'd1);
    send(8'h10, 8'h01, 8'h0F, 1'b0, 1'b0);
    drain();

    // WIDTH=1 instance: result one cycle after acceptance.
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("w1_in_ready", {63'd0, in_ready1}, 64'd1);
      a1 = w1_a[i];
      b1 = w1_b[i];
      in_valid1 = 1'b1;
      tick();
      in_valid1 = 1'b0;
      chk("w1_not_yet_valid", {63'd0, out_valid1}, 64'd0);
      tick();
      chk("w1_out_valid", {63'd0, out_valid1}, 64'd1);
      chk("w1_diff", {63'd0, diff1}, {63'd0, w1_d[i]});
      chk("w1_bout", {63'd0, bout1}, {63'd0, w1_bo[i]});
    end

    // Random operands with random out_ready duty.
    fork
      begin
        for (int i = 0; i < 400; i++) begin
          ra = 8'($urandom);
          rb = 8'($urandom);
          full = {1'b0, ra} - {1'b0, rb};
          send(ra, rb, full[7:0], full[8], (ra[7] ^ rb[7]) & (ra[7] ^ full[7]));
        end
        rnd_done = 1'b1;
      end
      begin
        while (!rnd_done) begin
          tick();
          out_ready = ($urandom_range(0, 3) != 0);
        end
        out_ready = 1'b1;
      end
    join
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
